// File: rtl/fu_writeback_tracker_pkg.sv
// fu_writeback_tracker_pkg: shared backend types for function-unit completion tracking
`ifndef IMUL_LATENCY
`define IMUL_LATENCY 5
`endif

package fu_writeback_tracker_pkg;

    localparam int PKG_PREG_W = 6;
    localparam int PKG_ROB_W  = 5;

    typedef enum logic [1:0] {
        FU_ALU,
        FU_BR,
        FU_IMUL
    } fu_sel_t;

    typedef struct packed {
        logic                  valid;
        fu_sel_t               fu;
        logic [PKG_PREG_W-1:0] rd;
        logic                  rd_en;
        logic [PKG_ROB_W-1:0]  rob;
    } wb_tag_t;

endpackage

// File: rtl/fu_writeback_tracker_if.sv
// fu_writeback_tracker_if: issue, flush, FU result and writeback signals of the tracker
interface fu_writeback_tracker_if #(
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
);
    import fu_writeback_tracker_pkg::*;

    logic              issue_valid;
    fu_sel_t           issue_fu;
    logic [PREG_W-1:0] issue_rd;
    logic              issue_rd_en;
    logic [ROB_W-1:0]  issue_rob;
    logic              issue_ready;
    logic [ROB_W-1:0]  rob_head;
    logic              flush_valid;
    logic [ROB_W-1:0]  flush_rob;
    logic [31:0]       alu_out;
    logic              br_out;
    logic [31:0]       imul_out;
    logic              wb_valid;
    fu_sel_t           wb_fu;
    logic [PREG_W-1:0] wb_rd;
    logic              wb_rd_en;
    logic [ROB_W-1:0]  wb_rob;
    logic [31:0]       wb_data;
    logic              wb_br_taken;

    modport master (
        output issue_valid, issue_fu, issue_rd, issue_rd_en, issue_rob,
        output rob_head, flush_valid, flush_rob, alu_out, br_out, imul_out,
        input  issue_ready, wb_valid, wb_fu, wb_rd, wb_rd_en, wb_rob, wb_data, wb_br_taken
    );

    modport slave (
        input  issue_valid, issue_fu, issue_rd, issue_rd_en, issue_rob,
        input  rob_head, flush_valid, flush_rob, alu_out, br_out, imul_out,
        output issue_ready, wb_valid, wb_fu, wb_rd, wb_rd_en, wb_rob, wb_data, wb_br_taken
    );

endinterface

// File: rtl/fu_writeback_tracker_rob_age_cmp.sv
// rob_age_cmp: modular ROB age test, true when a is younger than b relative to head
module rob_age_cmp #(
    parameter int ROB_W = 5
) (
    input  logic [ROB_W-1:0] head,
    input  logic [ROB_W-1:0] a,
    input  logic [ROB_W-1:0] b,
    output logic             a_younger_than_b
);
    logic [ROB_W-1:0] dist_a;
    logic [ROB_W-1:0] dist_b;

    assign dist_a           = a - head;
    assign dist_b           = b - head;
    assign a_younger_than_b = dist_a > dist_b;

endmodule

// File: rtl/fu_writeback_tracker.sv
// fu_writeback_tracker: tag pipeline aligning fixed-latency FU results with their writeback tags
module fu_writeback_tracker
    import fu_writeback_tracker_pkg::*;
#(
    parameter int PREG_W   = PKG_PREG_W,
    parameter int ROB_W    = PKG_ROB_W,
    parameter int IMUL_LAT = `IMUL_LATENCY
) (
    input  logic                            clock,
    input  logic                            reset,
    fu_writeback_tracker_if.slave           bus,
    output logic [$clog2(IMUL_LAT+1)-1:0]   inflight_cnt
);
    localparam int CW = $clog2(IMUL_LAT + 1);

    wb_tag_t           pipe [IMUL_LAT];
    wb_tag_t           nxt  [IMUL_LAT];
    wb_tag_t           issue_tag;
    logic [IMUL_LAT-1:0] young;
    logic              accept;
    logic [CW-1:0]     cnt_nxt;

    // young[0] judges the issuing uop; young[g] judges the entry about to shift down from pipe[g]
    for (genvar g = 0; g < IMUL_LAT; g++) begin : g_age
        rob_age_cmp #(.ROB_W(ROB_W)) u_age (
            .head             (bus.rob_head),
            .a                ((g == 0) ? bus.issue_rob : pipe[g].rob),
            .b                (bus.flush_rob),
            .a_younger_than_b (young[g])
        );
    end

    assign bus.issue_ready = (bus.issue_fu == FU_IMUL) | !pipe[1].valid;
    assign accept          = bus.issue_valid & bus.issue_ready & !(bus.flush_valid & young[0]);
    assign issue_tag       = '{valid: 1'b1, fu: bus.issue_fu, rd: bus.issue_rd[PREG_W-1:0],
                               rd_en: bus.issue_rd_en, rob: bus.issue_rob};

    // shift toward the writeback slot, dropping flushed entries, then insert the accepted uop at its latency
    always_comb begin
        for (int j = 0; j < IMUL_LAT - 1; j++) nxt[j] = (bus.flush_valid & young[j+1]) ? '0 : pipe[j+1];
        nxt[IMUL_LAT-1] = '0;
        if (accept) nxt[(bus.issue_fu == FU_IMUL) ? IMUL_LAT - 1 : 0] = issue_tag;
    end

    // occupancy of the next pipeline state, registered alongside it
    always_comb begin
        cnt_nxt = '0;
        for (int j = 0; j < IMUL_LAT; j++) cnt_nxt = cnt_nxt + CW'(nxt[j].valid);
    end

    // pipeline and occupancy registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe         <= '{default: '0};
            inflight_cnt <= '0;
        end else begin
            pipe         <= nxt;
            inflight_cnt <= cnt_nxt;
        end
    end

    assign bus.wb_valid    = pipe[0].valid;
    assign bus.wb_fu       = pipe[0].fu;
    assign bus.wb_rd       = pipe[0].rd;
    assign bus.wb_rd_en    = pipe[0].rd_en;
    assign bus.wb_rob      = pipe[0].rob;
    assign bus.wb_data     = !pipe[0].valid          ? '0 :
                             pipe[0].fu == FU_IMUL   ? bus.imul_out :
                             pipe[0].fu == FU_ALU    ? bus.alu_out : '0;
    assign bus.wb_br_taken = bus.br_out & (pipe[0].fu == FU_BR) & pipe[0].valid;

endmodule

// File: tb/tb_fu_writeback_tracker.sv
// tb_fu_writeback_tracker: directed scenarios plus randomized traffic against a latency-countdown model
module tb_fu_writeback_tracker;
    import fu_writeback_tracker_pkg::*;

    localparam int LAT = 5;
    localparam int RM  = 31;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] inflight_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    fu_writeback_tracker_if #(.PREG_W(6), .ROB_W(5)) bus ();

    fu_writeback_tracker #(.PREG_W(6), .ROB_W(5), .IMUL_LAT(LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .inflight_cnt (inflight_cnt)
    );

    always #5 clock = ~clock;

    // model: each in-flight op carries the number of cycles until its result lands
    typedef struct {
        fu_sel_t fu;
        int      rd;
        bit      rd_en;
        int      rob;
        int      rem;
    } op_t;

    op_t mq[$];

    function automatic bit m_young(int x);
        return ((x - int'(bus.rob_head)) & RM) > ((int'(bus.flush_rob) - int'(bus.rob_head)) & RM);
    endfunction

    function automatic bit m_ready();
        if (bus.issue_fu == FU_IMUL) return 1'b1;
        foreach (mq[i]) if (mq[i].rem == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_land();
        foreach (mq[i]) if (mq[i].rem == 0) return i;
        return -1;
    endfunction

    // advance one clock: compute the model's next state from the inputs currently driven
    task automatic step();
        op_t nq[$];
        op_t o;
        bit  acc;
        acc = bus.issue_valid && m_ready() && !(bus.flush_valid && m_young(int'(bus.issue_rob)));
        foreach (mq[i]) begin
            if (mq[i].rem != 0 && !(bus.flush_valid && m_young(mq[i].rob))) begin
                o = mq[i];
                o.rem = o.rem - 1;
                nq.push_back(o);
            end
        end
        if (acc) begin
            o.fu = bus.issue_fu;
            o.rd = int'(bus.issue_rd);
            o.rd_en = bus.issue_rd_en;
            o.rob = int'(bus.issue_rob);
            o.rem = (bus.issue_fu == FU_IMUL) ? LAT - 1 : 0;
            nq.push_back(o);
        end
        if (reset) nq.delete();
        @(posedge clock);
        mq = nq;
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.flush_valid = 1'b0;
    endtask

    task automatic set_issue(fu_sel_t fu, int rd, int rob);
        bus.issue_valid = 1'b1;
        bus.issue_fu    = fu;
        bus.issue_rd    = 6'(rd);
        bus.issue_rd_en = 1'b1;
        bus.issue_rob   = 5'(rob);
    endtask

    task automatic drain();
        idle();
        repeat (LAT + 1) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        bus.issue_fu = FU_ALU;
        #2;
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got %0d want 0", bus.wb_valid); end
        n_cmp++; if (bus.wb_data !== 32'h0) begin n_bad++; $display("FAIL reset_wb_data got %h want 0", bus.wb_data); end
        n_cmp++; if (bus.wb_rd !== 6'd0) begin n_bad++; $display("FAIL reset_wb_rd got %0d want 0", bus.wb_rd); end
        n_cmp++; if (inflight_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_inflight got %0d want 0", inflight_cnt); end
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0d want 1", bus.issue_ready); end
    endtask

    task automatic test_alu_basic();
        bus.rob_head = 5'd0;
        set_issue(FU_ALU, 7, 3);
        step();
        idle();
        bus.alu_out = 32'h1234;
        #2;
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL alu_wb_valid got %0d want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_rd !== 6'd7) begin n_bad++; $display("FAIL alu_wb_rd got %0d want 7", bus.wb_rd); end
        n_cmp++; if (bus.wb_rob !== 5'd3) begin n_bad++; $display("FAIL alu_wb_rob got %0d want 3", bus.wb_rob); end
        n_cmp++; if (bus.wb_data !== 32'h1234) begin n_bad++; $display("FAIL alu_wb_data got %h want 1234", bus.wb_data); end
        n_cmp++; if (inflight_cnt !== 3'd1) begin n_bad++; $display("FAIL alu_inflight got %0d want 1", inflight_cnt); end
        step();
    endtask

    task automatic test_imul_block();
        set_issue(FU_IMUL, 9, 4);
        step();
        idle();
        repeat (3) step();
        set_issue(FU_ALU, 10, 5);
        #2;
        n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL imul_block_ready got %0d want 0", bus.issue_ready); end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL imul_block_early_wb got %0d want 0", bus.wb_valid); end
        step();
        bus.imul_out = 32'hCAFE0001;
        bus.alu_out  = 32'h0BAD0002;
        #2;
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL imul_retry_ready got %0d want 1", bus.issue_ready); end
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_fu !== FU_IMUL) begin n_bad++; $display("FAIL imul_wb got v=%0d fu=%0d want v=1 fu=2", bus.wb_valid, bus.wb_fu); end
        n_cmp++; if (bus.wb_data !== 32'hCAFE0001) begin n_bad++; $display("FAIL imul_wb_data got %h want cafe0001", bus.wb_data); end
        step();
        idle();
        #2;
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_fu !== FU_ALU || bus.wb_rd !== 6'd10) begin n_bad++; $display("FAIL imul_then_alu got v=%0d fu=%0d rd=%0d want v=1 fu=0 rd=10", bus.wb_valid, bus.wb_fu, bus.wb_rd); end
        n_cmp++; if (bus.wb_data !== 32'h0BAD0002) begin n_bad++; $display("FAIL imul_then_alu_data got %h want 0bad0002", bus.wb_data); end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) set_issue(FU_ALU, i + 1, i + 1); else idle();
            #2;
            if (i > 0) begin
                n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 6'(i)) begin n_bad++; $display("FAIL b2b_wb[%0d] got v=%0d rd=%0d want v=1 rd=%0d", i, bus.wb_valid, bus.wb_rd, i); end
            end
            n_cmp++; if (inflight_cnt > 3'd1) begin n_bad++; $display("FAIL b2b_inflight[%0d] got %0d want <=1", i, inflight_cnt); end
            if (i < 5) begin
                n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %0d want 1", i, bus.issue_ready); end
            end
            step();
        end
        #2;
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_tail got %0d want 0", bus.wb_valid); end
    endtask

    task automatic test_wrap_flush();
        bit seen31 = 0;
        bit seen0  = 0;
        bit seen2  = 0;
        bus.rob_head = 5'd30;
        set_issue(FU_IMUL, 1, 31); step();
        set_issue(FU_IMUL, 2, 0);  step();
        set_issue(FU_IMUL, 3, 2);  step();
        idle();
        bus.flush_valid = 1'b1;
        bus.flush_rob   = 5'd0;
        step();
        idle();
        for (int i = 0; i < 6; i++) begin
            #2;
            if (bus.wb_valid === 1'b1 && bus.wb_rob === 5'd31) seen31 = 1;
            if (bus.wb_valid === 1'b1 && bus.wb_rob === 5'd0)  seen0 = 1;
            if (bus.wb_valid === 1'b1 && bus.wb_rob === 5'd2)  seen2 = 1;
            step();
        end
        n_cmp++; if (seen31 !== 1'b1) begin n_bad++; $display("FAIL wrap_rob31 got %0d want 1", seen31); end
        n_cmp++; if (seen0 !== 1'b1) begin n_bad++; $display("FAIL wrap_rob0 got %0d want 1", seen0); end
        n_cmp++; if (seen2 !== 1'b0) begin n_bad++; $display("FAIL wrap_rob2_killed got %0d want 0", seen2); end
        n_cmp++; if (inflight_cnt !== 3'd0) begin n_bad++; $display("FAIL wrap_inflight got %0d want 0", inflight_cnt); end
    endtask

    task automatic test_branch_and_flush();
        bus.rob_head = 5'd0;
        set_issue(FU_BR, 3, 1);
        step();
        idle();
        bus.alu_out = 32'h55;
        bus.br_out  = 1'b1;
        #2;
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_fu !== FU_BR) begin n_bad++; $display("FAIL br_wb got v=%0d fu=%0d want v=1 fu=1", bus.wb_valid, bus.wb_fu); end
        n_cmp++; if (bus.wb_br_taken !== 1'b1) begin n_bad++; $display("FAIL br_taken got %0d want 1", bus.wb_br_taken); end
        n_cmp++; if (bus.wb_data !== 32'h0) begin n_bad++; $display("FAIL br_data got %h want 0", bus.wb_data); end
        set_issue(FU_ALU, 5, 9);
        bus.flush_valid = 1'b1;
        bus.flush_rob   = 5'd4;
        step();
        idle();
        bus.br_out = 1'b0;
        #2;
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL sameflush_wb got %0d want 0", bus.wb_valid); end
        n_cmp++; if (inflight_cnt !== 3'd0) begin n_bad++; $display("FAIL sameflush_inflight got %0d want 0", inflight_cnt); end
        step();
    endtask

    task automatic test_reset_inflight();
        bus.rob_head = 5'd0;
        for (int i = 0; i < 3; i++) begin
            set_issue(FU_IMUL, i, i + 10);
            step();
        end
        idle();
        #2;
        n_cmp++; if (inflight_cnt !== 3'd3) begin n_bad++; $display("FAIL rstfl_pre_inflight got %0d want 3", inflight_cnt); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.issue_fu = FU_ALU;
        #2;
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL rstfl_wb got %0d want 0", bus.wb_valid); end
        n_cmp++; if (inflight_cnt !== 3'd0) begin n_bad++; $display("FAIL rstfl_inflight got %0d want 0", inflight_cnt); end
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL rstfl_ready got %0d want 1", bus.issue_ready); end
        step();
    endtask

    task automatic test_random();
        int  l;
        bit  ev;
        logic [31:0] ed;
        for (int c = 0; c < 600; c++) begin
            bus.issue_valid = ($urandom_range(0, 9) < 7);
            bus.issue_fu    = fu_sel_t'($urandom_range(0, 2));
            bus.issue_rd    = 6'($urandom);
            bus.issue_rd_en = 1'($urandom);
            bus.issue_rob   = 5'($urandom);
            bus.rob_head    = 5'($urandom);
            bus.flush_valid = ($urandom_range(0, 9) == 0);
            bus.flush_rob   = 5'($urandom);
            bus.alu_out     = $urandom;
            bus.imul_out    = $urandom;
            bus.br_out      = 1'($urandom);
            reset           = ($urandom_range(0, 99) == 0);
            #2;
            l  = m_land();
            ev = (l >= 0);
            ed = !ev ? 32'h0 : mq[l].fu == FU_IMUL ? bus.imul_out : mq[l].fu == FU_ALU ? bus.alu_out : 32'h0;
            n_cmp++; if (bus.issue_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready c=%0d got %0d want %0d", c, bus.issue_ready, m_ready()); end
            n_cmp++; if (bus.wb_valid !== ev) begin n_bad++; $display("FAIL rnd_wb_valid c=%0d got %0d want %0d", c, bus.wb_valid, ev); end
            n_cmp++; if (bus.wb_data !== ed) begin n_bad++; $display("FAIL rnd_wb_data c=%0d got %h want %h", c, bus.wb_data, ed); end
            n_cmp++; if (bus.wb_br_taken !== (ev && mq[l].fu == FU_BR && bus.br_out)) begin n_bad++; $display("FAIL rnd_br_taken c=%0d got %0d", c, bus.wb_br_taken); end
            n_cmp++; if (inflight_cnt !== 3'(mq.size())) begin n_bad++; $display("FAIL rnd_inflight c=%0d got %0d want %0d", c, inflight_cnt, mq.size()); end
            if (ev) begin
                n_cmp++; if (bus.wb_rd !== 6'(mq[l].rd) || bus.wb_rob !== 5'(mq[l].rob) || bus.wb_fu !== mq[l].fu || bus.wb_rd_en !== mq[l].rd_en) begin
                    n_bad++; $display("FAIL rnd_tag c=%0d got rd=%0d rob=%0d fu=%0d en=%0d want rd=%0d rob=%0d fu=%0d en=%0d", c, bus.wb_rd, bus.wb_rob, bus.wb_fu, bus.wb_rd_en, mq[l].rd, mq[l].rob, mq[l].fu, mq[l].rd_en);
                end
            end
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_fu    = FU_ALU;
        bus.issue_rd    = '0;
        bus.issue_rd_en = 1'b0;
        bus.issue_rob   = '0;
        bus.rob_head    = '0;
        bus.flush_valid = 1'b0;
        bus.flush_rob   = '0;
        bus.alu_out     = '0;
        bus.br_out      = 1'b0;
        bus.imul_out    = '0;
        #1;
        test_reset();
        test_alu_basic();
        drain();
        test_imul_block();
        drain();
        test_back_to_back();
        drain();
        test_wrap_flush();
        drain();
        test_branch_and_flush();
        drain();
        test_reset_inflight();
        drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
